sdram_slot_arbiter: RTL and testbench

Shares the single 8-bit SDRAM controller port between three requesters: ioctl/ROM loader, video fetch and CPU. Time is divided into slots of 8 clk cycles, aligned to rising edges of clkref, which is the same reference the SDRAM controller syncs to. The block grants at most one access per slot, drives the controller's addr/bank/din/oe/we for the whole slot, captures read data, and returns a one-cycle ack with data to the winner.

---
 rtl/sdram_arb_pkg.sv | 47 ++++
 rtl/sdram_slot_timer.sv | 44 ++++
 rtl/sdram_slot_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sdram_slot_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM slot arbiter.
// Contents: grant encoding, FSM state, per-slot command struct, slot timing defaults,
// and the fixed-priority and round-robin pick functions used at slot start.
package sdram_arb_pkg;

    localparam int SLOT_LEN_DEF = 8;  // clk cycles per clkref period
    localparam int CAP_CYC_DEF  = 7;  // slot_cnt value at which read data is taken
    localparam int NREQ         = 3;  // ioc, vid, cpu

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IOC  = 2'd1,
        GNT_VID  = 2'd2,
        GNT_CPU  = 2'd3
    } gnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Everything the controller needs for one slot.
    typedef struct packed {
        logic [22:0] addr;
        logic [1:0]  bank;
        logic [7:0]  din;
        logic        we;
    } ram_cmd_t;

    // req bit 0 = ioc, bit 1 = vid, bit 2 = cpu.
    function automatic gnt_t arb_fixed(input logic [NREQ-1:0] req);
        if (req[0])      return GNT_IOC;
        else if (req[1]) return GNT_VID;
        else if (req[2]) return GNT_CPU;
        else             return GNT_NONE;
    endfunction

    // ioc stays on top; vid/cpu tie goes to whichever was not served last.
    function automatic gnt_t arb_rr(input logic [NREQ-1:0] req, input logic last_vid);
        if (req[0])               return GNT_IOC;
        else if (req[1] && req[2]) return last_vid ? GNT_CPU : GNT_VID;
        else if (req[1])          return GNT_VID;
        else if (req[2])          return GNT_CPU;
        else                      return GNT_NONE;
    endfunction

endpackage

// File: rtl/sdram_slot_timer.sv
// Slot timer: detects clkref rising edges and counts clk cycles inside each slot.
// Ports: clk, reset (sync, active-high), clkref in; slot_start (one cycle, the cycle
// after the rise is seen), slot_cnt (0 in the slot_start cycle, saturates at SLOT_LEN-1).
module sdram_slot_timer #(
    parameter int SLOT_LEN = 8,
    parameter int CNT_W    = $clog2(SLOT_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clkref,
    output logic             slot_start,
    output logic [CNT_W-1:0] slot_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_LEN - 1);

    logic clkref_d;
    logic rise;

    // clkref_d deliberately tracks clkref through reset, so a clkref that is
    // already high when reset drops is not mistaken for a fresh slot boundary.
    always_ff @(posedge clk) begin
        clkref_d <= clkref;
    end

    assign rise = clkref & ~clkref_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_start <= 1'b0;
            slot_cnt   <= '0;
        end else if (rise) begin
            slot_start <= 1'b1;
            slot_cnt   <= '0;
        end else begin
            slot_start <= 1'b0;
            // Saturate so a stopped clkref leaves the count parked, not wrapping.
            if (slot_cnt != CNT_MAX) begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// Shares one 8-bit SDRAM controller port between ioc (loader), vid and cpu, one access per clkref slot.
// Ports: clk, reset (sync, active-high), clkref; per requester req/we/addr/bank/din in, ack/dout out;
// ram_addr/bank/din/oe/we to the controller, ram_dout from it; grant = current slot owner.
// Optional: define SDRAM_ARB_RR_EN for round-robin between vid and cpu (default: strict ioc > vid > cpu).
module sdram_slot_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int SLOT_LEN = SLOT_LEN_DEF,
    parameter int CAP_CYC  = CAP_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkref,

    input  logic        ioc_req,
    input  logic        ioc_we,
    input  logic [22:0] ioc_addr,
    input  logic [1:0]  ioc_bank,
    input  logic [7:0]  ioc_din,
    output logic        ioc_ack,
    output logic [7:0]  ioc_dout,

    input  logic        vid_req,
    input  logic        vid_we,
    input  logic [22:0] vid_addr,
    input  logic [1:0]  vid_bank,
    input  logic [7:0]  vid_din,
    output logic        vid_ack,
    output logic [7:0]  vid_dout,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [22:0] cpu_addr,
    input  logic [1:0]  cpu_bank,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,

    output logic [22:0] ram_addr,
    output logic [1:0]  ram_bank,
    output logic [7:0]  ram_din,
    output logic        ram_oe,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,

    output logic [1:0]  grant
);

    localparam int               CNT_W = $clog2(SLOT_LEN);
    localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAP_CYC);

    logic             slot_start;
    logic [CNT_W-1:0] slot_cnt;

    sdram_slot_timer #(
        .SLOT_LEN (SLOT_LEN),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clkref     (clkref),
        .slot_start (slot_start),
        .slot_cnt   (slot_cnt)
    );

    state_t    state;
    gnt_t      grant_q;
    logic      done;          // current slot's ack already issued
    logic [7:0] ioc_dout_q;
    logic [7:0] vid_dout_q;
    logic [7:0] cpu_dout_q;

    logic [NREQ-1:0] req_v;
    logic [NREQ-1:0] inflight;
    logic [NREQ-1:0] eligible;
    gnt_t            winner;
    ram_cmd_t        win_cmd;
    logic            cap_hit;

    assign req_v = {cpu_req, vid_req, ioc_req};

    // If a clkref edge arrives early and cuts a slot short before its ack,
    // the owner is still in flight: keep it out of this arbitration so it is
    // not granted twice for a single request.
    always_comb begin
        inflight = '0;
        if (state == BUSY && !done) begin
            case (grant_q)
                GNT_IOC: inflight[0] = 1'b1;
                GNT_VID: inflight[1] = 1'b1;
                GNT_CPU: inflight[2] = 1'b1;
                default: inflight    = '0;
            endcase
        end
    end

    assign eligible = req_v & ~inflight;

`ifdef SDRAM_ARB_RR_EN
    logic last_vid;  // 1 when the most recent vid/cpu grant went to vid
    assign winner = arb_rr(eligible, last_vid);
`else
    assign winner = arb_fixed(eligible);
`endif

    always_comb begin
        win_cmd = '0;
        case (winner)
            GNT_IOC: win_cmd = '{addr: ioc_addr, bank: ioc_bank, din: ioc_din, we: ioc_we};
            GNT_VID: win_cmd = '{addr: vid_addr, bank: vid_bank, din: vid_din, we: vid_we};
            GNT_CPU: win_cmd = '{addr: cpu_addr, bank: cpu_bank, din: cpu_din, we: cpu_we};
            default: win_cmd = '0;
        endcase
    end

    // The capture cycle of a granted slot; slot_cnt is 0 at slot_start, so
    // this never coincides with a new arbitration. Gating with reset drops
    // an ack that would otherwise land in the reset cycle.
    assign cap_hit = (state == BUSY) && !done && (slot_cnt == CAP_V) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= GNT_NONE;
            done       <= 1'b0;
            ram_addr   <= '0;
            ram_bank   <= '0;
            ram_din    <= '0;
            ram_oe     <= 1'b0;
            ram_we     <= 1'b0;
            ioc_dout_q <= '0;
            vid_dout_q <= '0;
            cpu_dout_q <= '0;
`ifdef SDRAM_ARB_RR_EN
            last_vid   <= 1'b0;
`endif
        end else if (slot_start) begin
            // Command is latched once and held for the whole slot; an empty
            // slot drops oe/we so the controller refreshes instead.
            grant_q  <= winner;
            state    <= (winner != GNT_NONE) ? BUSY : IDLE;
            done     <= 1'b0;
            ram_addr <= win_cmd.addr;
            ram_bank <= win_cmd.bank;
            ram_din  <= win_cmd.din;
            ram_oe   <= (winner != GNT_NONE) && !win_cmd.we;
            ram_we   <= (winner != GNT_NONE) &&  win_cmd.we;
`ifdef SDRAM_ARB_RR_EN
            if (winner == GNT_VID || winner == GNT_CPU) begin
                last_vid <= (winner == GNT_VID);
            end
`endif
        end else if (cap_hit) begin
            done <= 1'b1;
            if (!ram_we) begin
                case (grant_q)
                    GNT_IOC: ioc_dout_q <= ram_dout;
                    GNT_VID: vid_dout_q <= ram_dout;
                    GNT_CPU: cpu_dout_q <= ram_dout;
                    default: ;
                endcase
            end
        end
    end

    assign grant   = grant_q;
    assign ioc_ack = cap_hit && (grant_q == GNT_IOC);
    assign vid_ack = cap_hit && (grant_q == GNT_VID);
    assign cpu_ack = cap_hit && (grant_q == GNT_CPU);

    // Read data is sampled in the ack cycle itself; bypass the register so it
    // is already valid on the ack, then the register holds it afterwards.
    assign ioc_dout = (ioc_ack && !ram_we) ? ram_dout : ioc_dout_q;
    assign vid_dout = (vid_ack && !ram_we) ? ram_dout : vid_dout_q;
    assign cpu_dout = (cpu_ack && !ram_we) ? ram_dout : cpu_dout_q;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Directed bench for sdram_slot_arbiter: clkref every 8 clk, sampled 2 ns after each rising clk edge.
// ref_ph equals the DUT slot_cnt at every sample point (0 = slot_start cycle).
module tb_sdram_slot_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clkref;
    logic        ioc_req, vid_req, cpu_req;
    logic        ioc_we, vid_we, cpu_we;
    logic [22:0] ioc_addr, vid_addr, cpu_addr;
    logic [1:0]  ioc_bank, vid_bank, cpu_bank;
    logic [7:0]  ioc_din, vid_din, cpu_din;
    logic        ioc_ack, vid_ack, cpu_ack;
    logic [7:0]  ioc_dout, vid_dout, cpu_dout;
    logic [22:0] ram_addr;
    logic [1:0]  ram_bank;
    logic [7:0]  ram_din;
    logic        ram_oe, ram_we;
    logic [7:0]  ram_dout;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    sdram_slot_arbiter dut (
        .clk(clk), .reset(reset), .clkref(clkref),
        .ioc_req(ioc_req), .ioc_we(ioc_we), .ioc_addr(ioc_addr), .ioc_bank(ioc_bank),
        .ioc_din(ioc_din), .ioc_ack(ioc_ack), .ioc_dout(ioc_dout),
        .vid_req(vid_req), .vid_we(vid_we), .vid_addr(vid_addr), .vid_bank(vid_bank),
        .vid_din(vid_din), .vid_ack(vid_ack), .vid_dout(vid_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_bank(cpu_bank),
        .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .ram_addr(ram_addr), .ram_bank(ram_bank), .ram_din(ram_din),
        .ram_oe(ram_oe), .ram_we(ram_we), .ram_dout(ram_dout),
        .grant(grant)
    );

    always #5 clk = ~clk;

    // clkref generator: high for phases 0..3, rising when the phase wraps to 0.
    logic ref_run = 1'b0;
    int   ref_ph  = 7;
    always @(negedge clk) begin
        if (ref_run) begin
            ref_ph = (ref_ph == 7) ? 0 : ref_ph + 1;
            clkref = (ref_ph < 4);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ph0;
        for (int i = 0; i < 20 && ref_ph != 0; i++) tick;
        chk("align_ph0", ref_ph, 0);
    endtask

    // Per-slot observations, filled by obs_slot.
    logic [1:0]  g1;
    logic [22:0] a1;
    logic [1:0]  b1;
    logic [7:0]  d1;
    int          held, oe_n, we_n, gnz_n, ack_ph, ack_tot;
    int          ack_n [3];
    logic [7:0]  dout_at_ack;
    bit          auto_drop;

    // Starts at a ph0 sample; covers ph1..ph7 and the next ph0 (the 8 cycles
    // a granted command is held), ending on the next slot_start sample.
    task automatic obs_slot;
        held = 1; oe_n = 0; we_n = 0; gnz_n = 0; ack_ph = -1; ack_tot = 0;
        for (int k = 0; k < 3; k++) ack_n[k] = 0;
        dout_at_ack = 8'hxx;
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (i == 1) begin
                g1 = grant; a1 = ram_addr; b1 = ram_bank; d1 = ram_din;
            end
            if (grant != g1 || ram_addr != a1 || ram_bank != b1 || ram_din != d1) held = 0;
            if (ram_oe) oe_n++;
            if (ram_we) we_n++;
            if (grant != 2'd0) gnz_n++;
            if (ioc_ack) begin ack_n[0]++; ack_ph = i; dout_at_ack = ioc_dout; if (auto_drop) ioc_req = 0; end
            if (vid_ack) begin ack_n[1]++; ack_ph = i; dout_at_ack = vid_dout; if (auto_drop) vid_req = 0; end
            if (cpu_ack) begin ack_n[2]++; ack_ph = i; dout_at_ack = cpu_dout; if (auto_drop) cpu_req = 0; end
        end
        ack_tot = ack_n[0] + ack_n[1] + ack_n[2];
    endtask

    logic [1:0] exp_rr [4];
    logic [7:0] exp_d3 [3];

    initial begin
        reset = 1; clkref = 0; ram_dout = 0; auto_drop = 1;
        ioc_req = 0; vid_req = 0; cpu_req = 0;
        ioc_we = 0; vid_we = 0; cpu_we = 0;
        ioc_addr = 0; vid_addr = 0; cpu_addr = 0;
        ioc_bank = 0; vid_bank = 0; cpu_bank = 0;
        ioc_din = 0; vid_din = 0; cpu_din = 0;
        repeat (3) tick;

        // Reset state
        chk("rst_grant", grant, 0);
        chk("rst_oe_we", {ram_oe, ram_we}, 0);
        chk("rst_ram_bus", {ram_addr, ram_bank, ram_din}, 0);
        chk("rst_acks", {ioc_ack, vid_ack, cpu_ack}, 0);
        chk("rst_douts", {ioc_dout, vid_dout, cpu_dout}, 0);

        // 1: cpu read of 23'h000123, controller returns 5A
        cpu_req = 1; cpu_we = 0; cpu_addr = 23'h000123; cpu_bank = 2'd1; ram_dout = 8'h5A;
        reset = 0; ref_run = 1;
        wait_ph0;
        obs_slot;
        chk("rd_grant", g1, 3);
        chk("rd_addr", a1, 23'h000123);
        chk("rd_oe_cycles", oe_n, 8);
        chk("rd_we_cycles", we_n, 0);
        chk("rd_held", held, 1);
        chk("rd_ack_count", ack_n[2], 1);
        chk("rd_ack_phase", ack_ph, 7);
        chk("rd_dout_on_ack", dout_at_ack, 8'h5A);
        chk("rd_dout_held", cpu_dout, 8'h5A);

        // 2: all three requests in one cycle -> ioc, vid, cpu in consecutive slots
        ioc_req = 1; ioc_addr = 23'h000010;
        vid_req = 1; vid_addr = 23'h000020;
        cpu_req = 1; cpu_addr = 23'h000030;
        exp_d3[0] = 8'h11; exp_d3[1] = 8'h22; exp_d3[2] = 8'h33;
        for (int s = 0; s < 3; s++) begin
            ram_dout = exp_d3[s];
            obs_slot;
            chk($sformatf("all3_grant_%0d", s), g1, s + 1);
            chk($sformatf("all3_acks_%0d", s), ack_tot, 1);
            chk($sformatf("all3_own_ack_%0d", s), ack_n[s], 1);
        end
        chk("all3_ioc_dout", ioc_dout, 8'h11);
        chk("all3_vid_dout", vid_dout, 8'h22);
        chk("all3_cpu_dout", cpu_dout, 8'h33);

        // 3: cpu write C3 to bank 2; dout must keep 33
        cpu_req = 1; cpu_we = 1; cpu_din = 8'hC3; cpu_bank = 2'd2; cpu_addr = 23'h000055;
        ram_dout = 8'hEE;
        obs_slot;
        chk("wr_grant", g1, 3);
        chk("wr_we_cycles", we_n, 8);
        chk("wr_oe_cycles", oe_n, 0);
        chk("wr_din", d1, 8'hC3);
        chk("wr_bank", b1, 2'd2);
        chk("wr_held", held, 1);
        chk("wr_ack", ack_n[2], 1);
        chk("wr_dout_unchanged", cpu_dout, 8'h33);
        cpu_we = 0;

        // 4: four idle slots
        for (int s = 0; s < 4; s++) begin
            obs_slot;
            chk($sformatf("idle_oe_we_%0d", s), oe_n + we_n, 0);
            chk($sformatf("idle_grant_%0d", s), gnz_n, 0);
        end

        // 5: vid and cpu held high continuously. The last vid/cpu grant went to cpu.
`ifdef SDRAM_ARB_RR_EN
        exp_rr[0] = 2; exp_rr[1] = 3; exp_rr[2] = 2; exp_rr[3] = 3;
`else
        exp_rr[0] = 2; exp_rr[1] = 2; exp_rr[2] = 2; exp_rr[3] = 2;
`endif
        auto_drop = 0;
        vid_req = 1; cpu_req = 1; ram_dout = 8'h44;
        for (int s = 0; s < 4; s++) begin
            obs_slot;
            chk($sformatf("cont_grant_%0d", s), g1, exp_rr[s]);
            chk($sformatf("cont_acks_%0d", s), ack_tot, 1);
        end
        vid_req = 0; cpu_req = 0; auto_drop = 1;

        // 6: reset at slot_cnt 3 of a vid read
        obs_slot;  // empty slot so the next one starts cleanly
        vid_req = 1; vid_we = 0; vid_addr = 23'h7ABCDE; vid_bank = 2'd3; ram_dout = 8'h99;
        repeat (3) tick;
        chk("rst_mid_grant_before", grant, 2);
        chk("rst_mid_oe_before", ram_oe, 1);
        reset = 1;
        tick;
        chk("rst_mid_grant", grant, 0);
        chk("rst_mid_oe_we", {ram_oe, ram_we}, 0);
        chk("rst_mid_bus", {ram_addr, ram_bank, ram_din}, 0);
        chk("rst_mid_douts", {ioc_dout, vid_dout, cpu_dout}, 0);
        reset = 0;
        ack_tot = 0;
        for (int i = 0; i < 4; i++) begin
            if (vid_ack) ack_tot++;
            tick;
        end
        chk("rst_mid_no_ack", ack_tot, 0);
        chk("rst_mid_realign", ref_ph, 0);
        obs_slot;
        chk("post_rst_grant", g1, 2);
        chk("post_rst_addr", a1, 23'h7ABCDE);
        chk("post_rst_bank", b1, 2'd3);
        chk("post_rst_ack", ack_n[1], 1);
        chk("post_rst_dout", vid_dout, 8'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
